// File: rtl/ibuf_mc_ctrl_pkg.sv
// Shared definitions for the multicast input-buffer controller:
// direction indices, power-gating states and a popcount helper.
package ibuf_pkg;

    localparam int DIR_N = 0;
    localparam int DIR_W = 1;
    localparam int DIR_S = 2;
    localparam int DIR_E = 3;
    localparam int DIR_B = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        OFF   = 2'd2
    } pg_state_t;

    function automatic logic [5:0] popcount(
        input logic [31:0] v
    );
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/ibuf_mc_ctrl_if.sv
// Upstream, arbiter, fault, power-gate and statistics bundle of
// the multicast input-buffer controller.
interface ibuf_mc_ctrl_if #(
    parameter int PYLD_W  = 23,
    parameter int NUM_DIR = 5,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic               in_vld;
    logic               in_rdy;
    logic [NUM_DIR-1:0] in_route;
    logic [PYLD_W-1:0]  in_pyld;
    logic [NUM_DIR-1:0] dead_mask;
    logic               pg_en;
    logic               pg_ack;
    logic [NUM_DIR-1:0] arb_req;
    logic [NUM_DIR-1:0] arb_gnt;
    logic [NUM_DIR-1:0] obuf_rdy;
    logic [PYLD_W-1:0]  pyld_o;
    logic [OCC_W-1:0]   occ;
    logic               drop_pulse;
    logic [CNT_W-1:0]   stat_fwd;
    logic [CNT_W-1:0]   stat_drop;

    modport master (
        output in_vld, in_route, in_pyld, dead_mask,
        output pg_en, arb_gnt, obuf_rdy,
        input  in_rdy, pg_ack, arb_req, pyld_o,
        input  occ, drop_pulse, stat_fwd, stat_drop
    );

    modport slave (
        input  in_vld, in_route, in_pyld, dead_mask,
        input  pg_en, arb_gnt, obuf_rdy,
        output in_rdy, pg_ack, arb_req, pyld_o,
        output occ, drop_pulse, stat_fwd, stat_drop
    );

endinterface

// File: rtl/ibuf_mc_ctrl_fifo_mem.sv
// Register-array flit FIFO; the head entry's route mask is
// rewritable in place so copies can retire one at a time.
module ibuf_fifo_mem #(
    parameter int PYLD_W  = 23,
    parameter int NUM_DIR = 5,
    parameter int DEPTH   = 4,
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [NUM_DIR-1:0] wr_mask,
    input  logic [PYLD_W-1:0]  wr_pyld,
    input  logic               hd_upd,
    input  logic [NUM_DIR-1:0] hd_mask_nxt,
    input  logic               pop,
    output logic [NUM_DIR-1:0] hd_mask,
    output logic [PYLD_W-1:0]  hd_pyld,
    output logic [OCC_W-1:0]   occ,
    output logic               empty,
    output logic               full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [NUM_DIR-1:0] mask_q [DEPTH];
    logic [PYLD_W-1:0]  pyld_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
                pyld_q[i] <= '0;
            end
        end else begin
            if (hd_upd) mask_q[rd_ptr] <= hd_mask_nxt;
            if (wr_en) begin
                mask_q[wr_ptr] <= wr_mask;
                pyld_q[wr_ptr] <= wr_pyld;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign hd_mask = mask_q[rd_ptr];
    assign hd_pyld = pyld_q[rd_ptr];
    assign occ     = occ_q;
    assign empty   = (occ_q == '0);
    assign full    = (occ_q == OCC_W'(DEPTH));

endmodule

// File: rtl/ibuf_mc_ctrl.sv
// Multicast input-port buffer controller with fault masking and
// drain-then-off power gating. Optional counters: IBUF_STATS_EN.
module ibuf_mc_ctrl
    import ibuf_pkg::*;
#(
    parameter int PYLD_W  = 23,
    parameter int NUM_DIR = 5,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst_n,
    ibuf_mc_ctrl_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    pg_state_t          st_q, st_d;
    logic [NUM_DIR-1:0] push_mask, hd_mask, live, clr, nxt;
    logic [PYLD_W-1:0]  hd_pyld;
    logic [OCC_W-1:0]   occ;
    logic               empty, full, active;
    logic               acc, wr_en, drop, pop, drop_q;

    assign push_mask = bus.in_route & ~bus.dead_mask;
    assign acc       = bus.in_vld & bus.in_rdy;
    assign wr_en     = acc & (|push_mask);
    assign drop      = acc & ~(|push_mask);

    // Dead directions retire silently: they never reach clr.
    assign active = !empty && (st_q != OFF);
    assign live   = hd_mask & ~bus.dead_mask;
    assign clr    = bus.arb_req & bus.arb_gnt & bus.obuf_rdy;
    assign nxt    = live & ~clr;
    assign pop    = active && (nxt == '0);

    ibuf_fifo_mem #(
        .PYLD_W  (PYLD_W),
        .NUM_DIR (NUM_DIR),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_mask     (push_mask),
        .wr_pyld     (bus.in_pyld),
        .hd_upd      (active),
        .hd_mask_nxt (nxt),
        .pop         (pop),
        .hd_mask     (hd_mask),
        .hd_pyld     (hd_pyld),
        .occ         (occ),
        .empty       (empty),
        .full        (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= RUN;
            drop_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            drop_q <= drop;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            RUN:     if (bus.pg_en) st_d = DRAIN;
            DRAIN: begin
                if (!bus.pg_en) st_d = RUN;
                else if (empty) st_d = OFF;
            end
            OFF:     if (!bus.pg_en) st_d = RUN;
            default: st_d = RUN;
        endcase
    end

    assign bus.in_rdy     = !full && (st_q == RUN);
    assign bus.pg_ack     = (st_q == OFF);
    assign bus.arb_req    = active ? live : '0;
    assign bus.pyld_o     = empty ? '0 : hd_pyld;
    assign bus.occ        = occ;
    assign bus.drop_pulse = drop_q;

`ifdef IBUF_STATS_EN
    logic [CNT_W-1:0] fwd_q, drp_q;
    logic [CNT_W:0]   fwd_sum;

    assign fwd_sum = {1'b0, fwd_q}
                   + (CNT_W+1)'(popcount(32'(clr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= '0;
            drp_q <= '0;
        end else begin
            fwd_q <= fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
            if (drop && (drp_q != '1)) drp_q <= drp_q + 1'b1;
        end
    end

    assign bus.stat_fwd  = fwd_q;
    assign bus.stat_drop = drp_q;
`else
    assign bus.stat_fwd  = '0;
    assign bus.stat_drop = '0;
`endif

endmodule

// File: tb/tb_ibuf_mc_ctrl.sv
// Randomised scoreboard bench for ibuf_mc_ctrl against a
// queue-based flit model.
module tb_ibuf_mc_ctrl;
    import ibuf_pkg::*;

    localparam int PYLD_W  = 23;
    localparam int NUM_DIR = 5;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic [NUM_DIR-1:0] m;
        logic [PYLD_W-1:0]  p;
    } flit_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    flit_t q[$];
    int    m_st = 0;
    logic  m_drop = 1'b0;
    int    m_fwd = 0;
    int    m_dcnt = 0;

    always #5 clk = ~clk;

    ibuf_mc_ctrl_if #(
        .PYLD_W(PYLD_W), .NUM_DIR(NUM_DIR),
        .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) bus ();

    ibuf_mc_ctrl #(
        .PYLD_W(PYLD_W), .NUM_DIR(NUM_DIR),
        .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic mreset();
        q.delete();
        m_st   = 0;
        m_drop = 1'b0;
        m_fwd  = 0;
        m_dcnt = 0;
    endtask

    // Reference: one edge of the buffer as a flit queue.
    task automatic mstep();
        int sz;
        logic rdy;
        logic [NUM_DIR-1:0] live, c, nm;
        sz  = q.size();
        rdy = (sz < DEPTH) && (m_st == 0);
        if (sz > 0 && m_st != 2) begin
            live  = q[0].m & ~bus.dead_mask;
            c     = live & bus.arb_gnt & bus.obuf_rdy;
            m_fwd = sat(m_fwd + $countones(c));
            nm    = live & ~c;
            if (nm == '0) void'(q.pop_front());
            else q[0].m = nm;
        end
        m_drop = 1'b0;
        if (bus.in_vld && rdy) begin
            nm = bus.in_route & ~bus.dead_mask;
            if (nm == '0) begin
                m_drop = 1'b1;
                m_dcnt = sat(m_dcnt + 1);
            end else begin
                q.push_back('{nm, bus.in_pyld});
            end
        end
        case (m_st)
            0: if (bus.pg_en) m_st = 1;
            1: if (!bus.pg_en) m_st = 0;
               else if (sz == 0) m_st = 2;
            2: if (!bus.pg_en) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep();
        end
    end

    task automatic check_all();
        logic [NUM_DIR-1:0] er;
        logic [PYLD_W-1:0]  ep;
        er = '0;
        ep = '0;
        if (q.size() > 0) begin
            ep = q[0].p;
            if (m_st != 2) er = q[0].m & ~bus.dead_mask;
        end
        chk("arb_req", 32'(bus.arb_req), 32'(er));
        chk("pyld_o", 32'(bus.pyld_o), 32'(ep));
        chk("occ", 32'(bus.occ), 32'(q.size()));
        chk("in_rdy", 32'(bus.in_rdy),
            32'((q.size() < DEPTH) && (m_st == 0)));
        chk("pg_ack", 32'(bus.pg_ack), 32'(m_st == 2));
        chk("drop_pulse", 32'(bus.drop_pulse), 32'(m_drop));
`ifdef IBUF_STATS_EN
        chk("stat_fwd", 32'(bus.stat_fwd), 32'(m_fwd));
        chk("stat_drop", 32'(bus.stat_drop), 32'(m_dcnt));
`else
        chk("stat_fwd", 32'(bus.stat_fwd), 32'(0));
        chk("stat_drop", 32'(bus.stat_drop), 32'(0));
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) check_all();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_vld   = 1'b0;
        bus.dead_mask = '0;
        bus.arb_gnt  = '1;
        bus.obuf_rdy = '1;
        bus.pg_en    = 1'b0;
        repeat (12) cyc();
    endtask

    logic [NUM_DIR-1:0] gseq [6];
    int k;

    initial begin
        bus.in_vld    = 1'b0;
        bus.in_route  = '0;
        bus.in_pyld   = '0;
        bus.dead_mask = '0;
        bus.pg_en     = 1'b0;
        bus.arb_gnt   = '0;
        bus.obuf_rdy  = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc();

        // Unicast stream.
        bus.arb_gnt  = '1;
        bus.obuf_rdy = '1;
        for (int i = 0; i < 3; i++) begin
            bus.in_vld   = 1'b1;
            bus.in_route = 5'b00001;
            bus.in_pyld  = PYLD_W'($urandom);
            cyc();
        end
        bus.in_vld = 1'b0;
        repeat (5) cyc();

        // Multicast with staggered grants.
        bus.arb_gnt  = '0;
        bus.in_vld   = 1'b1;
        bus.in_route = 5'b10110;
        bus.in_pyld  = PYLD_W'($urandom);
        cyc();
        bus.in_vld = 1'b0;
        gseq = '{5'b00010, 5'b0, 5'b00100,
                 5'b0, 5'b0, 5'b10000};
        for (int i = 0; i < 6; i++) begin
            bus.arb_gnt = gseq[i];
            cyc();
        end
        bus.arb_gnt = '0;
        repeat (2) cyc();

        // Route fully dead: drop.
        bus.dead_mask = 5'b00100;
        bus.in_vld    = 1'b1;
        bus.in_route  = 5'b00100;
        cyc();
        bus.in_vld    = 1'b0;
        bus.dead_mask = '0;
        repeat (2) cyc();

        // Direction dies mid-service.
        bus.in_vld   = 1'b1;
        bus.in_route = 5'b00110;
        bus.in_pyld  = PYLD_W'($urandom);
        cyc();
        bus.in_vld = 1'b0;
        cyc();
        bus.dead_mask = 5'b00100;
        cyc();
        bus.dead_mask = '0;
        bus.arb_gnt   = 5'b00010;
        cyc();
        bus.arb_gnt = '0;
        repeat (2) cyc();

        // Fill to full under backpressure, then release.
        bus.obuf_rdy = '0;
        bus.arb_gnt  = '1;
        bus.in_vld   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_route = NUM_DIR'($urandom_range(1, 31));
            bus.in_pyld  = PYLD_W'($urandom);
            cyc();
        end
        bus.in_vld   = 1'b0;
        bus.obuf_rdy = '1;
        repeat (10) cyc();

        // Power gating with two flits queued.
        bus.obuf_rdy = '0;
        bus.in_vld   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_route = 5'b01000;
            bus.in_pyld  = PYLD_W'($urandom);
            cyc();
        end
        bus.in_vld = 1'b0;
        bus.pg_en  = 1'b1;
        repeat (2) cyc();
        bus.obuf_rdy = '1;
        k = 0;
        while (k < 50 && !bus.pg_ack) begin
            cyc();
            k++;
        end
        chk("pg_ack_timeout", 32'(bus.pg_ack), 32'(1));
        repeat (2) cyc();
        bus.pg_en = 1'b0;
        repeat (3) cyc();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            bus.in_vld   = 1'($urandom_range(0, 1));
            bus.in_route = NUM_DIR'($urandom);
            bus.in_pyld  = PYLD_W'($urandom);
            bus.dead_mask = ($urandom_range(0, 9) == 0)
                          ? NUM_DIR'($urandom) : '0;
            bus.arb_gnt  = NUM_DIR'($urandom);
            bus.obuf_rdy = NUM_DIR'($urandom);
            if ($urandom_range(0, 39) == 0)
                bus.pg_en = !bus.pg_en;
            cyc();
        end
        drain();

        // Async reset mid-multicast with three queued.
        bus.arb_gnt = '0;
        bus.in_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_route = 5'b10110;
            bus.in_pyld  = PYLD_W'($urandom);
            cyc();
        end
        bus.in_vld  = 1'b0;
        bus.arb_gnt = 5'b00010;
        cyc();
        bus.arb_gnt = '0;
        chk("occ_pre_rst", 32'(bus.occ), 32'(3));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_arb_req", 32'(bus.arb_req), 32'(0));
        chk("rst_occ", 32'(bus.occ), 32'(0));
        chk("rst_pyld", 32'(bus.pyld_o), 32'(0));
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'(1));
        chk("rst_pg_ack", 32'(bus.pg_ack), 32'(0));
        chk("rst_drop", 32'(bus.drop_pulse), 32'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
